yuv422_job_sequencer: RTL and testbench

- Job-level controller for the RGB888-to-YUV422 converter.
- Holds a host-writable bank of signed conversion coefficients and accepts job requests carrying a pixel count.
- Per job: streams the coefficient set, then the pixel count, to the converter's configuration handshakes.
- Monitors Y/U/V output-stream transfers and signals completion, busy status and protocol errors to the host.

---
 rtl/yuv422_job_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_yuv422_job_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_job_sequencer.sv
// ---------------------------------------------------------------------------
// yuv422_job_sequencer
//
// Job-level controller for the RGB888-to-YUV422 converter. It holds a
// host-writable bank of signed conversion coefficients. For each job it sends
// the coefficient set and then the pixel count to the converter. It then
// counts Y/U/V output transfers until the job is complete.
//
// Optional feature (macro YUV422_SEQ_COEFF_CACHE_EN):
//   When the macro is defined, a dirty bit tracks whether the bank changed
//   since the converter last received the full coefficient set. A clean bank
//   lets a job skip LOAD_COEFF. When the macro is undefined, every non-empty
//   job reloads all coefficients.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata
//                            coefficient bank write. Out-of-range addresses
//                            are ignored. A write while busy is dropped.
//   start_valid/ready/count  job request handshake carrying the pixel count
//   coeff_valid/ready/data   coefficient stream to the converter
//   pixel_count_valid/ready/pixel_count
//                            pixel count handshake to the converter
//   y_fire/u_fire/v_fire     converter output-stream transfer indications
//   busy                     high whenever the FSM is not in IDLE
//   done                     one-cycle job-complete pulse
//   cfg_drop                 sticky flag: a cfg write was attempted while busy
//   overrun                  sticky flag: unexpected or surplus output fire
// ---------------------------------------------------------------------------
module yuv422_job_sequencer #(
  parameter int NUM_COEFF = 9,
  parameter int COEFF_W   = 9,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [COEFF_W-1:0] cfg_wdata,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [CNT_W-1:0]   start_count,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic [COEFF_W-1:0] coeff_data,
  output logic               pixel_count_valid,
  input  logic               pixel_count_ready,
  output logic [CNT_W-1:0]   pixel_count,
  input  logic               y_fire,
  input  logic               u_fire,
  input  logic               v_fire,
  output logic               busy,
  output logic               done,
  output logic               cfg_drop,
  output logic               overrun
);

  localparam int                IDX_W       = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_COEFF - 1);
  localparam logic [4:0]        NUM_COEFF_A = 5'(NUM_COEFF);
  // Expected counts carry one extra bit, so (N+1)>>1 never truncates.
  localparam int                EW          = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_COEFF,
    S_SEND_COUNT,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [COEFF_W-1:0]      r_bank [NUM_COEFF];
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_count;
  logic [EW-1:0]           r_exp_y;
  logic [EW-1:0]           r_exp_uv;
  logic [2:0][EW-1:0]      r_cnt;       // [0]=Y, [1]=U, [2]=V
  logic                    r_cfg_drop;
  logic                    r_overrun;

  logic                    w_idle;
  logic                    w_bank_wr;
  logic [NUM_COEFF-1:0]    w_bank_we;
  logic                    w_counting;
  logic                    w_skip_load;
  logic [2:0]              w_fire;
  logic [2:0][EW-1:0]      w_exp;
  logic [2:0][EW-1:0]      w_cnt_next;
  logic [2:0]              w_full;
  logic [2:0]              w_inc;
  logic [2:0]              w_ovr;
  logic [2:0]              w_hit;

  assign w_idle     = (r_state == S_IDLE);
  assign w_bank_wr  = w_idle && cfg_we && ({1'b0, cfg_addr} < NUM_COEFF_A);
  assign w_counting = (r_state == S_SEND_COUNT) || (r_state == S_RUN);
  assign w_fire     = {v_fire, u_fire, y_fire};
  assign w_exp[0]   = r_exp_y;
  assign w_exp[1]   = r_exp_uv;
  assign w_exp[2]   = r_exp_uv;

  // Per-entry bank write decode.
  for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_bank_we
    assign w_bank_we[gi] = w_bank_wr && (cfg_addr == 4'(gi));
  end

  // Per-channel fire accounting. A fire on a full channel is reported as an
  // overrun and never increments the counter. w_hit includes this cycle's
  // fires, so completion is detected on the cycle of the last transfer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign w_full[gi]     = (r_cnt[gi] == w_exp[gi]);
    assign w_inc[gi]      = w_counting && w_fire[gi] && !w_full[gi];
    assign w_ovr[gi]      = w_fire[gi] && (!w_counting || w_full[gi]);
    assign w_cnt_next[gi] = r_cnt[gi] + EW'(w_inc[gi]);
    assign w_hit[gi]      = (w_cnt_next[gi] == w_exp[gi]);
  end

`ifdef YUV422_SEQ_COEFF_CACHE_EN
  logic r_dirty;

  // A write accepted in the same cycle as the start must still force a
  // reload, so it is OR-ed into the current dirty state.
  assign w_skip_load = !(r_dirty || w_bank_wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dirty <= 1'b1;
    end else if (w_bank_wr) begin
      r_dirty <= 1'b1;
    end else if (r_state == S_LOAD_COEFF && coeff_ready && r_idx == LAST_IDX) begin
      r_dirty <= 1'b0;
    end
  end
`else
  assign w_skip_load = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next      = r_state;
    start_ready       = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    coeff_valid       = 1'b0;
    pixel_count_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          if (start_count == '0) begin
            w_state_next = S_DONE;
          end else if (w_skip_load) begin
            w_state_next = S_SEND_COUNT;
          end else begin
            w_state_next = S_LOAD_COEFF;
          end
        end
      end
      S_LOAD_COEFF: begin
        coeff_valid = 1'b1;
        if (coeff_ready && r_idx == LAST_IDX) begin
          w_state_next = S_SEND_COUNT;
        end
      end
      S_SEND_COUNT: begin
        pixel_count_valid = 1'b1;
        if (pixel_count_ready) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (&w_hit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Data outputs are zero outside their handshake phases.
  assign coeff_data  = coeff_valid ? r_bank[r_idx] : '0;
  assign pixel_count = pixel_count_valid ? r_count : '0;
  assign cfg_drop    = r_cfg_drop;
  assign overrun     = r_overrun;

  // Coefficient bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (w_bank_we[i]) begin
          r_bank[i] <= cfg_wdata;
        end
      end
    end
  end

  // Coefficient index, job parameters, counters and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_count    <= '0;
      r_exp_y    <= '0;
      r_exp_uv   <= '0;
      r_cnt      <= '0;
      r_cfg_drop <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == S_LOAD_COEFF && coeff_ready) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
      if (w_idle && start_valid) begin
        r_count  <= start_count;
        r_exp_y  <= {1'b0, start_count};
        r_exp_uv <= ({1'b0, start_count} + EW'(1)) >> 1;
      end
      if (r_state == S_DONE) begin
        r_cnt <= '0;
      end else if (w_counting) begin
        r_cnt <= w_cnt_next;
      end
      if (cfg_we && !w_idle) begin
        r_cfg_drop <= 1'b1;
      end
      if (|w_ovr) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_yuv422_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_yuv422_job_sequencer
//
// Self-checking bench for yuv422_job_sequencer. A behavioural model is kept
// as plain variables: a bank copy, remaining fire counts per channel, a dirty
// flag and the sticky flags. Each job is checked cycle by cycle against the
// handshake order: coefficients, then the count, then the fires, then done.
// ---------------------------------------------------------------------------
module tb_yuv422_job_sequencer;

  localparam int NUM_COEFF = 9;
  localparam int COEFF_W   = 9;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [COEFF_W-1:0] cfg_wdata;
  logic               start_valid;
  logic               start_ready;
  logic [CNT_W-1:0]   start_count;
  logic               coeff_valid;
  logic               coeff_ready;
  logic [COEFF_W-1:0] coeff_data;
  logic               pixel_count_valid;
  logic               pixel_count_ready;
  logic [CNT_W-1:0]   pixel_count;
  logic               y_fire, u_fire, v_fire;
  logic               busy, done, cfg_drop, overrun;

  yuv422_job_sequencer #(
    .NUM_COEFF(NUM_COEFF), .COEFF_W(COEFF_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start_valid(start_valid), .start_ready(start_ready), .start_count(start_count),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
    .pixel_count_valid(pixel_count_valid), .pixel_count_ready(pixel_count_ready),
    .pixel_count(pixel_count),
    .y_fire(y_fire), .u_fire(u_fire), .v_fire(v_fire),
    .busy(busy), .done(done), .cfg_drop(cfg_drop), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model state
  logic [COEFF_W-1:0] m_bank [NUM_COEFF];
  bit                 m_dirty;
  bit                 m_overrun;
  bit                 m_cfg_drop;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NUM_COEFF; i++) m_bank[i] = '0;
    m_dirty    = 1'b1;
    m_overrun  = 1'b0;
    m_cfg_drop = 1'b0;
  endtask

  function automatic bit model_reload();
`ifdef YUV422_SEQ_COEFF_CACHE_EN
    return m_dirty;
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_inputs;
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    start_valid = 0; start_count = '0;
    coeff_ready = 0; pixel_count_ready = 0;
    y_fire = 0; u_fire = 0; v_fire = 0;
  endtask

  // Bank write issued in IDLE. Out-of-range addresses leave the model untouched.
  task automatic cfg_write(input int addr, input logic [COEFF_W-1:0] data);
    cfg_we = 1; cfg_addr = 4'(addr); cfg_wdata = data;
    tick;
    cfg_we = 0;
    if (addr < NUM_COEFF) begin
      m_bank[addr] = data;
      m_dirty      = 1'b1;
    end
    $display("cfg write addr=%0d data=%h", addr, data);
  endtask

  // Run one complete job and check every cycle against the model.
  task automatic run_job(input int n, input int rdy_pct, input int fire_pct,
                         input bit inj_ovr, input bit drop_wr, input bit start_wr);
    int  ry, ru, rv, idx, guard;
    bit  reload, injected, rdy, fy, fu, fv, finished;
    logic [3:0]         wa;
    logic [COEFF_W-1:0] wd;
    injected = 0;

    vec_cnt++;
    if ({start_ready, busy, done} !== 3'b100) begin
      err_cnt++;
      $display("FAIL idle_status n=%0d: got rdy/busy/done=%b expected 100", n, {start_ready, busy, done});
    end
    start_valid = 1; start_count = CNT_W'(n);
    if (start_wr) begin
      wa = 4'($urandom_range(0, NUM_COEFF - 1)); wd = COEFF_W'($urandom);
      cfg_we = 1; cfg_addr = wa; cfg_wdata = wd;
      m_bank[wa] = wd; m_dirty = 1'b1;
    end
    reload = model_reload();
    tick;
    start_valid = 0; cfg_we = 0;

    if (n == 0) begin
      vec_cnt++;
      if ({busy, done, coeff_valid, pixel_count_valid, start_ready} !== 5'b11000) begin
        err_cnt++;
        $display("FAIL zero_done: got busy/done/cv/pv/rdy=%b expected 11000",
                 {busy, done, coeff_valid, pixel_count_valid, start_ready});
      end
      tick;
      vec_cnt++;
      if ({busy, done, start_ready} !== 3'b001) begin
        err_cnt++;
        $display("FAIL zero_return: got busy/done/rdy=%b expected 001", {busy, done, start_ready});
      end
      $display("job n=0 complete");
      return;
    end

    ry = n; ru = (n + 1) / 2; rv = ru;

    if (reload) begin
      idx = 0; guard = 0;
      while (idx < NUM_COEFF && guard < 2000) begin
        vec_cnt++;
        if ({busy, done, coeff_valid, pixel_count_valid} !== 4'b1010 || coeff_data !== m_bank[idx]) begin
          err_cnt++;
          $display("FAIL coeff idx=%0d: got valid=%b pv=%b data=%h expected valid=1 pv=0 data=%h",
                   idx, coeff_valid, pixel_count_valid, coeff_data, m_bank[idx]);
        end
        if (drop_wr && guard == 0) begin
          cfg_we = 1; cfg_addr = 4'd0; cfg_wdata = ~m_bank[0];
          m_cfg_drop = 1'b1;
        end
        rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        coeff_ready = rdy;
        tick;
        coeff_ready = 0; cfg_we = 0;
        if (rdy) idx++;
        guard++;
      end
      if (idx < NUM_COEFF) begin
        vec_cnt++; err_cnt++;
        $display("FAIL coeff_timeout: got %0d handshakes expected %0d", idx, NUM_COEFF);
      end
      m_dirty = 1'b0;
    end

    guard = 0; rdy = 0;
    while (!rdy && guard < 2000) begin
      vec_cnt++;
      if ({busy, done, coeff_valid, pixel_count_valid} !== 4'b1001 || pixel_count !== CNT_W'(n)) begin
        err_cnt++;
        $display("FAIL count_phase: got cv=%b pv=%b count=%0d expected cv=0 pv=1 count=%0d",
                 coeff_valid, pixel_count_valid, pixel_count, n);
      end
      rdy = (int'($urandom_range(0, 99)) < rdy_pct);
      pixel_count_ready = rdy;
      tick;
      pixel_count_ready = 0;
      guard++;
    end

    guard = 0; finished = 0;
    while (!finished && guard < 4000) begin
      vec_cnt++;
      if ({busy, done, coeff_valid, pixel_count_valid, start_ready} !== 5'b10000) begin
        err_cnt++;
        $display("FAIL run_phase: got busy/done/cv/pv/rdy=%b expected 10000 (rem y=%0d u=%0d v=%0d)",
                 {busy, done, coeff_valid, pixel_count_valid, start_ready}, ry, ru, rv);
      end
      fy = (ry > 0) && (int'($urandom_range(0, 99)) < fire_pct);
      fu = (ru > 0) && (int'($urandom_range(0, 99)) < fire_pct);
      fv = (rv > 0) && (int'($urandom_range(0, 99)) < fire_pct);
      if (inj_ovr && !injected && rv == 0 && (ry > 0 || ru > 0)) begin
        fv = 1; injected = 1;
      end
      if (fy) begin if (ry == 0) m_overrun = 1'b1; else ry--; end
      if (fu) begin if (ru == 0) m_overrun = 1'b1; else ru--; end
      if (fv) begin if (rv == 0) m_overrun = 1'b1; else rv--; end
      y_fire = fy; u_fire = fu; v_fire = fv;
      tick;
      y_fire = 0; u_fire = 0; v_fire = 0;
      guard++;
      finished = (ry == 0 && ru == 0 && rv == 0);
    end
    if (!finished) begin
      vec_cnt++; err_cnt++;
      $display("FAIL run_timeout: got remaining y=%0d u=%0d v=%0d expected 0", ry, ru, rv);
    end

    vec_cnt++;
    if ({busy, done, start_ready} !== 3'b110) begin
      err_cnt++;
      $display("FAIL done_pulse n=%0d: got busy/done/rdy=%b expected 110", n, {busy, done, start_ready});
    end
    tick;
    vec_cnt++;
    if ({busy, done, start_ready, cfg_drop, overrun} !== {3'b001, m_cfg_drop, m_overrun}) begin
      err_cnt++;
      $display("FAIL job_end n=%0d: got busy/done/rdy/drop/ovr=%b expected %b", n,
               {busy, done, start_ready, cfg_drop, overrun}, {3'b001, m_cfg_drop, m_overrun});
    end
    $display("job n=%0d reload=%0b complete, overrun=%0b cfg_drop=%0b", n, reload, overrun, cfg_drop);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    repeat (2) tick;
    model_reset();
    vec_cnt++;
    if ({start_ready, busy, done, coeff_valid, pixel_count_valid, cfg_drop, overrun} !== 7'b1000000 ||
        coeff_data !== '0 || pixel_count !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: got %b data=%h count=%h expected 1000000 data=0 count=0",
               {start_ready, busy, done, coeff_valid, pixel_count_valid, cfg_drop, overrun},
               coeff_data, pixel_count);
    end
    rst = 0;
    tick;
    vec_cnt++;
    if ({start_ready, busy, done} !== 3'b100) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got %b expected 100", {start_ready, busy, done});
    end
    $display("reset checked");
  endtask

  task automatic test_basic;
    cfg_write(0, 9'h100);  // -256
    for (int i = 1; i < NUM_COEFF; i++) cfg_write(i, COEFF_W'(i));
    cfg_write(9, 9'h1AA);  // out of range, ignored
    cfg_write(15, 9'h055); // out of range, ignored
    run_job(4, 100, 100, 0, 0, 0);
  endtask

  task automatic test_odd_overrun;
    run_job(5, 100, 100, 1, 0, 0);
  endtask

  task automatic test_cfg_drop_reset;
    bit reload;
    cfg_write(2, 9'h1F0);
    run_job(3, 100, 100, 0, 1, 0);   // write during LOAD_COEFF is dropped
    run_job(2, 100, 100, 0, 0, 0);   // still sends the old bank
    // Abort a job in RUN with reset.
    reload = model_reload();
    start_valid = 1; start_count = 16'd7;
    coeff_ready = 1; pixel_count_ready = 1;
    tick;
    start_valid = 0;
    repeat (reload ? NUM_COEFF + 1 : 1) tick;
    coeff_ready = 0; pixel_count_ready = 0;
    vec_cnt++;
    if ({busy, done, coeff_valid, pixel_count_valid} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL mid_run_state: got busy/done/cv/pv=%b expected 1000",
               {busy, done, coeff_valid, pixel_count_valid});
    end
    y_fire = 1;
    tick;
    y_fire = 0;
    rst = 1;
    tick;
    rst = 0;
    model_reset();
    vec_cnt++;
    if ({start_ready, busy, done, coeff_valid, pixel_count_valid, cfg_drop, overrun} !== 7'b1000000 ||
        coeff_data !== '0 || pixel_count !== '0) begin
      err_cnt++;
      $display("FAIL mid_run_reset: got %b expected 1000000",
               {start_ready, busy, done, coeff_valid, pixel_count_valid, cfg_drop, overrun});
    end
    // A fire while idle sets overrun.
    u_fire = 1;
    tick;
    u_fire = 0;
    m_overrun = 1'b1;
    vec_cnt++;
    if (overrun !== 1'b1) begin
      err_cnt++;
      $display("FAIL idle_fire_overrun: got %b expected 1", overrun);
    end
    run_job(1, 100, 100, 0, 0, 0);   // bank must read back as zeros
  endtask

  task automatic test_zero_count;
    run_job(0, 100, 100, 0, 0, 0);
    run_job(0, 100, 100, 0, 0, 1);
  endtask

  task automatic test_cache_reuse;
    run_job(3, 100, 100, 0, 0, 0);
    run_job(2, 100, 100, 0, 0, 0);
    cfg_write(4, COEFF_W'($urandom));
    run_job(2, 100, 100, 0, 0, 0);
  endtask

  task automatic test_back_to_back_random;
    for (int j = 0; j < 14; j++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, 15)), COEFF_W'($urandom));
      run_job(int'($urandom_range(0, 10)), 50, 60, 0, 0, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_overrun();
    test_cfg_drop_reset();
    test_zero_count();
    test_cache_reuse();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
